// File: rtl/pipe_pkg.sv
// Shared types and constants for the EX stage: ALU op codes, FSM states,
// the registered output bundle and the single-cycle ALU function.
package pipe_pkg;

  localparam int DATA_W   = 16;
  localparam int REG_W    = 4;
  localparam int MUL_ITER = 16;
  localparam int CNT_W    = $clog2(MUL_ITER);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLL = 4'd5,
    OP_SRL = 4'd6,
    OP_SLT = 4'd7,
    OP_MUL = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } ex_state_e;

  typedef struct packed {
    logic                stall;
    logic [DATA_W-1:0]   result;
    logic [DATA_W-1:0]   lsadr;
    logic [2*DATA_W-1:0] store_data;
    logic                mem_read;
    logic                mem_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                reg_write;
    logic [REG_W-1:0]    rs;
    logic [REG_W-1:0]    rt;
    logic [REG_W-1:0]    rd;
  } ex_out_t;

  // MUL and unused codes yield 0 here; the product comes from mul_iter16.
  function automatic logic [DATA_W-1:0] alu_compute(input logic [3:0]        op,
                                                    input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    r = '0;
    case (alu_op_e'(op))
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << b[3:0];
      OP_SRL:  r = a >> b[3:0];
      OP_SLT:  r = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mul_iter16.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low 16 bits
// of the unsigned product. `done` marks the cycle of the final iteration.
module mul_iter16
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] multiplicand_in,
  input  logic [DATA_W-1:0] multiplier_in,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  logic              active_q, active_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;

  assign done    = active_q && (cnt_q == CNT_W'(MUL_ITER - 1));
  assign product = acc_q;

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start) begin
      active_d = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = multiplicand_in;
      mplier_d = multiplier_in;
    end else if (active_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (done) active_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// EX pipeline stage: single-cycle ALU and address generation, plus a
// 16-iteration multiply that raises `busy` and emits bubbles while running.
module execute_stage
  import pipe_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_in,
  input  logic [DATA_W-1:0]   operand_a,
  input  logic [DATA_W-1:0]   operand_b,
  input  logic [DATA_W-1:0]   imm,
  input  logic [3:0]          alu_op,
  input  logic                alu_src,
  input  logic [2*DATA_W-1:0] store_data_in,
  input  logic                MemRead_in,
  input  logic                MemWrite_in,
  input  logic                RegDst_in,
  input  logic                MemtoReg_in,
  input  logic                RegWrite_in,
  input  logic [REG_W-1:0]    rs_in,
  input  logic [REG_W-1:0]    rt_in,
  input  logic [REG_W-1:0]    rd_in,
  output logic                busy,
  output logic                stall_out,
  output logic [DATA_W-1:0]   result_out,
  output logic [DATA_W-1:0]   lsadr_out,
  output logic [2*DATA_W-1:0] store_data_out,
  output logic                MemRead_out,
  output logic                MemWrite_out,
  output logic                RegDst_out,
  output logic                MemtoReg_out,
  output logic                RegWrite_out,
  output logic [REG_W-1:0]    rs_out,
  output logic [REG_W-1:0]    rt_out,
  output logic [REG_W-1:0]    rd_out
);

  ex_state_e         state_q, state_d;
  logic              busy_q, busy_d;
  ex_out_t           out_q, out_d;
  ex_out_t           held_q, held_d;   // MUL control/indices awaiting the product
  ex_out_t           fresh;
  logic [DATA_W-1:0] b_val;
  logic              mul_start, mul_done;
  logic [DATA_W-1:0] mul_product;

  mul_iter16 u_mul (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (mul_start),
    .multiplicand_in (operand_a),
    .multiplier_in   (b_val),
    .done            (mul_done),
    .product         (mul_product)
  );

  always_comb begin
    b_val            = alu_src ? imm : operand_b;
    fresh            = '0;
    fresh.result     = alu_compute(alu_op, operand_a, b_val);
    fresh.lsadr      = operand_a + imm;
    fresh.store_data = store_data_in;
    fresh.mem_read   = MemRead_in;
    fresh.mem_write  = MemWrite_in;
    fresh.reg_dst    = RegDst_in;
    fresh.mem_to_reg = MemtoReg_in;
    fresh.reg_write  = RegWrite_in;
    fresh.rs         = rs_in;
    fresh.rt         = rt_in;
    fresh.rd         = rd_in;

    state_d   = state_q;
    busy_d    = busy_q;
    out_d     = out_q;
    held_d    = held_q;
    mul_start = 1'b0;

    case (state_q)
      IDLE: begin
        if (stall_in || (alu_op == OP_MUL)) begin
          out_d.stall     = 1'b1;
          out_d.reg_write = 1'b0;
          out_d.mem_read  = 1'b0;
          out_d.mem_write = 1'b0;
        end else begin
          out_d = fresh;
        end
        if (!stall_in && (alu_op == OP_MUL)) begin
          held_d    = fresh;
          mul_start = 1'b1;
          busy_d    = 1'b1;
          state_d   = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        if (mul_done) state_d = MUL_DONE;
      end
      MUL_DONE: begin
        out_d        = held_q;
        out_d.result = mul_product;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      out_q       <= '0;
      out_q.stall <= 1'b1;
      held_q      <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      out_q   <= out_d;
      held_q  <= held_d;
    end
  end

  assign busy           = busy_q;
  assign stall_out      = out_q.stall;
  assign result_out     = out_q.result;
  assign lsadr_out      = out_q.lsadr;
  assign store_data_out = out_q.store_data;
  assign MemRead_out    = out_q.mem_read;
  assign MemWrite_out   = out_q.mem_write;
  assign RegDst_out     = out_q.reg_dst;
  assign MemtoReg_out   = out_q.mem_to_reg;
  assign RegWrite_out   = out_q.reg_write;
  assign rs_out         = out_q.rs;
  assign rt_out         = out_q.rt;
  assign rd_out         = out_q.rd;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases followed by random
// traffic, every cycle compared against a cycle-count reference model.
module tb_execute_stage;

  localparam int ITERS = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_in;
  logic [15:0] operand_a, operand_b, imm;
  logic [3:0]  alu_op;
  logic        alu_src;
  logic [31:0] store_data_in;
  logic        MemRead_in, MemWrite_in, RegDst_in, MemtoReg_in, RegWrite_in;
  logic [3:0]  rs_in, rt_in, rd_in;
  logic        busy, stall_out;
  logic [15:0] result_out, lsadr_out;
  logic [31:0] store_data_out;
  logic        MemRead_out, MemWrite_out, RegDst_out, MemtoReg_out, RegWrite_out;
  logic [3:0]  rs_out, rt_out, rd_out;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in),
    .operand_a(operand_a), .operand_b(operand_b), .imm(imm),
    .alu_op(alu_op), .alu_src(alu_src), .store_data_in(store_data_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .RegDst_in(RegDst_in),
    .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
    .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in),
    .busy(busy), .stall_out(stall_out), .result_out(result_out),
    .lsadr_out(lsadr_out), .store_data_out(store_data_out),
    .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
    .RegDst_out(RegDst_out), .MemtoReg_out(MemtoReg_out),
    .RegWrite_out(RegWrite_out),
    .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out)
  );

  typedef struct {
    logic        stall;
    logic [15:0] result;
    logic [15:0] lsadr;
    logic [31:0] sd;
    logic        mr, mw, rdst, m2r, rw;
    logic [3:0]  rs, rt, rd;
  } exp_t;

  exp_t exp_o, pending;
  logic exp_busy;
  int   mul_left;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [15:0] ref_alu(input int op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] prod;
    int sa, sb;
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    prod = 32'(a) * 32'(b);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << (b % 16);
      6: return a >> (b % 16);
      7: return (sa < sb) ? 16'd1 : 16'd0;
      8: return prod[15:0];
      default: return 16'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic make_bubble();
    exp_o.stall = 1'b1;
    exp_o.rw    = 1'b0;
    exp_o.mr    = 1'b0;
    exp_o.mw    = 1'b0;
  endtask

  // Model of what the registered outputs become at the coming rising edge.
  task automatic model_edge();
    exp_t        fresh;
    logic [15:0] bsel;
    bsel         = alu_src ? imm : operand_b;
    fresh.stall  = 1'b0;
    fresh.result = ref_alu(int'(alu_op), operand_a, bsel);
    fresh.lsadr  = operand_a + imm;
    fresh.sd     = store_data_in;
    fresh.mr     = MemRead_in;
    fresh.mw     = MemWrite_in;
    fresh.rdst   = RegDst_in;
    fresh.m2r    = MemtoReg_in;
    fresh.rw     = RegWrite_in;
    fresh.rs     = rs_in;
    fresh.rt     = rt_in;
    fresh.rd     = rd_in;
    if (!rst_n) begin
      exp_o       = '{default: '0};
      exp_o.stall = 1'b1;
      exp_busy    = 1'b0;
      mul_left    = 0;
    end else if (mul_left > 0) begin
      mul_left--;
      if (mul_left == 0) begin
        exp_o    = pending;
        exp_busy = 1'b0;
      end
    end else if (stall_in) begin
      make_bubble();
    end else if (alu_op == 4'd8) begin
      pending  = fresh;
      mul_left = ITERS + 1;
      exp_busy = 1'b1;
      make_bubble();
    end else begin
      exp_o = fresh;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".busy"},   busy,           exp_busy);
    chk({tag, ".stall"},  stall_out,      exp_o.stall);
    chk({tag, ".result"}, result_out,     exp_o.result);
    chk({tag, ".lsadr"},  lsadr_out,      exp_o.lsadr);
    chk({tag, ".sdata"},  store_data_out, exp_o.sd);
    chk({tag, ".ctrl"},   {MemRead_out, MemWrite_out, RegDst_out, MemtoReg_out, RegWrite_out},
                          {exp_o.mr, exp_o.mw, exp_o.rdst, exp_o.m2r, exp_o.rw});
    chk({tag, ".idx"},    {rs_out, rt_out, rd_out}, {exp_o.rs, exp_o.rt, exp_o.rd});
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] im, input logic src);
    alu_op = op; operand_a = a; operand_b = b; imm = im; alu_src = src;
  endtask

  task automatic set_ctrl(input logic rw, input logic mr, input logic mw, input logic [3:0] rd);
    RegWrite_in = rw; MemRead_in = mr; MemWrite_in = mw; rd_in = rd;
  endtask

  task automatic rand_inputs();
    stall_in      = ($urandom_range(0, 3) == 0);
    operand_a     = 16'($urandom);
    operand_b     = 16'($urandom);
    imm           = 16'($urandom);
    alu_op        = 4'($urandom_range(0, 15));
    alu_src       = 1'($urandom);
    store_data_in = $urandom;
    {MemRead_in, MemWrite_in, RegDst_in, MemtoReg_in, RegWrite_in} = 5'($urandom);
    rs_in = 4'($urandom); rt_in = 4'($urandom); rd_in = 4'($urandom);
  endtask

  initial begin
    int cnt;
    exp_o    = '{default: '0};
    pending  = '{default: '0};
    exp_busy = 1'b0;
    mul_left = 0;
    rst_n    = 1'b0;
    stall_in = 1'b0;
    set_instr(4'd0, 16'h0, 16'h0, 16'h0, 1'b0);
    store_data_in = 32'h0;
    {MemRead_in, MemWrite_in, RegDst_in, MemtoReg_in, RegWrite_in} = 5'b0;
    rs_in = 4'h0; rt_in = 4'h0; rd_in = 4'h0;

    // Reset held two cycles
    step("reset0");
    step("reset1");
    chk("reset_stall_out", stall_out, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_result", result_out, 16'h0);

    // Single-cycle ops
    rst_n = 1'b1;
    set_ctrl(1'b1, 1'b0, 1'b0, 4'h3);
    store_data_in = 32'hDEAD_BEEF; rs_in = 4'h1; rt_in = 4'h2; RegDst_in = 1'b1;
    set_instr(4'd0, 16'hFFFF, 16'h1234, 16'h0002, 1'b1);
    step("add");
    chk("add_result", result_out, 16'h0001);
    chk("add_lsadr", lsadr_out, 16'h0001);
    set_instr(4'd7, 16'h8000, 16'h0001, 16'h0000, 1'b0);
    step("slt");
    chk("slt_neg", result_out, 16'h0001);
    set_instr(4'd7, 16'h0001, 16'h8000, 16'h0000, 1'b0);
    step("slt_swap");
    chk("slt_swap", result_out, 16'h0000);
    set_instr(4'd5, 16'h0001, 16'h0013, 16'h0000, 1'b0);
    step("sll");
    chk("sll_result", result_out, 16'h0008);

    // Directed multiply with stall_in toggling while busy
    set_ctrl(1'b1, 1'b0, 1'b0, 4'h7);
    set_instr(4'd8, 16'h0123, 16'h0045, 16'h0000, 1'b0);
    step("mul_accept");
    cnt = 0;
    for (int k = 0; k < 40 && busy === 1'b1; k++) begin
      cnt++;
      chk("mul_bubble", stall_out, 1'b1);
      stall_in  = k[0];
      operand_a = 16'($urandom);
      alu_op    = 4'($urandom_range(0, 15));
      step("mul_wait");
    end
    chk("mul_busy_cycles", cnt, 17);
    chk("mul_result", result_out, 16'h4E6F);
    chk("mul_rd", rd_out, 4'h7);
    chk("mul_regwrite", RegWrite_out, 1'b1);

    // stall_in in IDLE: bubble, data held
    stall_in = 1'b0;
    set_instr(4'd0, 16'h0010, 16'h0020, 16'h0000, 1'b0);
    step("pre_stall_add");
    stall_in = 1'b1;
    set_instr(4'd1, 16'h0999, 16'h0001, 16'h0000, 1'b0);
    step("idle_stall");
    chk("stall_bubble", stall_out, 1'b1);
    chk("stall_hold_result", result_out, 16'h0030);
    chk("stall_regwrite", RegWrite_out, 1'b0);

    // Back-to-back multiplies: second accepted the cycle busy falls
    stall_in = 1'b0;
    set_instr(4'd8, 16'h0003, 16'h0005, 16'h0000, 1'b0);
    step("b2b_accept");
    for (int k = 0; k < 40 && busy === 1'b1; k++) step("b2b_wait1");
    chk("b2b_first_result", result_out, 16'h000F);
    step("b2b_second");
    chk("b2b_no_dead_cycle", busy, 1'b1);
    for (int k = 0; k < 40 && busy === 1'b1; k++) step("b2b_wait2");
    chk("b2b_second_result", result_out, 16'h000F);

    // Reset during iteration 8 aborts the multiply
    set_instr(4'd8, 16'h0101, 16'h0202, 16'h0000, 1'b0);
    step("abort_accept");
    for (int k = 0; k < 8; k++) step("abort_iter");
    rst_n = 1'b0;
    step("abort_reset");
    chk("abort_busy", busy, 1'b0);
    chk("abort_stall", stall_out, 1'b1);
    chk("abort_result", result_out, 16'h0000);
    rst_n = 1'b1;
    set_instr(4'd0, 16'h0005, 16'h0006, 16'h0000, 1'b0);
    step("post_abort_add");
    chk("post_abort_result", result_out, 16'h000B);
    chk("post_abort_busy", busy, 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      rst_n = ($urandom_range(0, 149) != 0);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
